// File: rtl/bmp_upload.sv
// Streams the framebuffer back to data_io as a 32-bpp bottom-up BMP: a constant header
// followed by SDRAM words fetched over a toggle handshake. Define BMP_UPLOAD_ALPHA_EN to pass lane 3 through.
module bmp_upload #(
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 312,
  parameter logic [7:0]  INDEX     = 8'h00,
  parameter logic [21:0] BASE_ADDR = 22'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [21:0] mem_addr,
  input  logic [31:0] mem_q,
  output logic        busy,
  output logic        underrun
);

  localparam logic [31:0] IMG    = 32'(WIDTH * HEIGHT * 4);
  localparam logic [31:0] FSIZE  = IMG + 32'd54;
  localparam logic [22:0] NWORDS = 23'(IMG >> 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_READY} state_t;
  state_t state, state_d;

  logic        active, active_q, start;
  logic        ack_ph, pend, ack_ev;
  logic [22:0] tgt, tgt_d, cur_k;
  logic [31:0] cur_w, nxt_w;
  logic        cur_v, nxt_v;
  logic        do_req, st_cur, st_nxt, shift;
  logic [7:0]  din_d;

  assign active = ioctl_upload && (ioctl_index == INDEX);
  assign start  = active && !active_q;
  assign busy   = active_q;
  // ack_ph follows mem_ack every cycle, so any toggle (ours or stale) shows up exactly once
  assign ack_ev = (mem_ack != ack_ph);

  // address decode
  logic [31:0] addr32;
  logic [24:0] idx;
  logic [22:0] widx;
  logic [1:0]  lane;
  logic        in_hdr, in_pix, hit_cur, hit_nxt;

  assign addr32  = {7'd0, ioctl_addr};
  assign in_hdr  = addr32 < 32'd54;
  assign in_pix  = !in_hdr && (addr32 < FSIZE);
  assign idx     = ioctl_addr - 25'd54;
  assign widx    = idx[24:2];
  assign lane    = idx[1:0];
  assign hit_cur = cur_v && (widx == cur_k);
  assign hit_nxt = nxt_v && (widx == cur_k + 23'd1);

  // Header from byte 2 onward is a run of 32-bit LE fields; planes/bpp pack into one field.
  function automatic logic [7:0] hdr_byte(input logic [5:0] a);
    logic [5:0]  off;
    logic [31:0] f;
    off = a - 6'd2;
    case (off[5:2])
      4'd0:        f = FSIZE;
      4'd2:        f = 32'd54;
      4'd3:        f = 32'd40;
      4'd4:        f = 32'(WIDTH);
      4'd5:        f = 32'(HEIGHT);
      4'd6:        f = 32'h0020_0001;
      4'd8:        f = IMG;
      4'd9, 4'd10: f = 32'd2835;
      default:     f = 32'd0;
    endcase
    if (a == 6'd0)      hdr_byte = 8'h42;
    else if (a == 6'd1) hdr_byte = 8'h4D;
    else                hdr_byte = f[{off[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] pix_byte(input logic [31:0] w, input logic [1:0] l);
`ifdef BMP_UPLOAD_ALPHA_EN
    pix_byte = w[{l, 3'b000} +: 8];
`else
    pix_byte = (l == 2'd3) ? 8'h00 : w[{l, 3'b000} +: 8];
`endif
  endfunction

  always_comb begin
    din_d = 8'h00;
    if (active) begin
      if (in_hdr) din_d = hdr_byte(ioctl_addr[5:0]);
      else if (in_pix) begin
        if (hit_cur)      din_d = pix_byte(cur_w, lane);
        else if (hit_nxt) din_d = pix_byte(nxt_w, lane);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    do_req  = 1'b0;
    st_cur  = 1'b0;
    st_nxt  = 1'b0;
    shift   = 1'b0;
    if (!active) state_d = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (start) begin
          state_d = S_FETCH;
          tgt_d   = 23'd0;
        end
        // a stale request from an aborted upload must drain before a new one is issued
        S_FETCH: if (!pend) begin
          do_req  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: if (ack_ev && pend) begin
          st_cur = !cur_v;
          st_nxt = cur_v;
          if (!cur_v && (tgt + 23'd1 < NWORDS)) begin
            state_d = S_FETCH;
            tgt_d   = tgt + 23'd1;
          end else state_d = S_READY;
        end
        S_READY: if (nxt_v && in_pix && (widx == cur_k + 23'd1)) begin
          shift = 1'b1;
          if (cur_k + 23'd2 < NWORDS) begin
            state_d = S_FETCH;
            tgt_d   = cur_k + 23'd2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      ack_ph    <= 1'b0;
      pend      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 22'd0;
      tgt       <= 23'd0;
      cur_k     <= 23'd0;
      cur_w     <= 32'd0;
      nxt_w     <= 32'd0;
      cur_v     <= 1'b0;
      nxt_v     <= 1'b0;
      ioctl_din <= 8'h00;
      underrun  <= 1'b0;
    end else begin
      active_q  <= active;
      ack_ph    <= mem_ack;
      tgt       <= tgt_d;
      ioctl_din <= din_d;
      if (ack_ev) pend <= 1'b0;
      if (do_req) begin
        mem_req  <= ~mem_req;
        mem_addr <= BASE_ADDR + tgt[21:0];
        pend     <= 1'b1;
      end
      if (!active || state == S_IDLE) begin
        cur_v <= 1'b0;
        nxt_v <= 1'b0;
      end else begin
        if (st_cur) begin
          cur_w <= mem_q;
          cur_v <= 1'b1;
          cur_k <= tgt;
        end
        if (st_nxt) begin
          nxt_w <= mem_q;
          nxt_v <= 1'b1;
        end
        if (shift) begin
          cur_w <= nxt_w;
          cur_k <= cur_k + 23'd1;
          nxt_v <= 1'b0;
        end
      end
      if (start) underrun <= 1'b0;
      else if (ioctl_rd && active && in_pix && !hit_cur && !hit_nxt) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmp_upload.sv
// Directed bench: a 640x312 instance for header/stream checks and a 2x2 instance for end-of-image.
module tb_bmp_upload;
  logic        clk_sys = 1'b0, reset = 1'b1, ioctl_upload = 1'b0, ioctl_rd = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  din0, din1;
  logic        mreq0, mreq1, busy0, busy1, urun0, urun1;
  logic [21:0] maddr0, maddr1;
  logic        mack[2];
  logic [31:0] mq[2];
  logic        mr[2];
  logic [21:0] ma[2];
  int          checks = 0, failures = 0;
  int          lat = 8;
  logic        poison = 1'b0;
  int          reqcnt[2] = '{0, 0};
  int          ackcnt[2] = '{0, 0};
  logic [21:0] rlog[2][0:255];
  int          r0s, r1s;

`ifdef BMP_UPLOAD_ALPHA_EN
  localparam logic [7:0] A0 = 8'h11, A1 = 8'h55, A2 = 8'hC0, A3 = 8'hC0;
`else
  localparam logic [7:0] A0 = 8'h00, A1 = 8'h00, A2 = 8'h00, A3 = 8'h00;
`endif

  always #5 clk_sys = ~clk_sys;

  bmp_upload #(.WIDTH(640), .HEIGHT(312), .INDEX(8'h00), .BASE_ADDR(22'h0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(din0), .mem_req(mreq0),
    .mem_ack(mack[0]), .mem_addr(maddr0), .mem_q(mq[0]), .busy(busy0), .underrun(urun0));

  bmp_upload #(.WIDTH(2), .HEIGHT(2), .INDEX(8'h00), .BASE_ADDR(22'h100)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(din1), .mem_req(mreq1),
    .mem_ack(mack[1]), .mem_addr(maddr1), .mem_q(mq[1]), .busy(busy1), .underrun(urun1));

  assign mr[0] = mreq0;
  assign mr[1] = mreq1;
  assign ma[0] = maddr0;
  assign ma[1] = maddr1;

  function automatic logic [31:0] mword(input logic [21:0] k);
    if (k == 22'd0)      mword = 32'h11223344;
    else if (k == 22'd1) mword = 32'h55667788;
    else                 mword = 32'hC0DE0000 | 32'(k);
  endfunction

  // toggle-handshake SDRAM port model with programmable latency, one per instance
  logic        last[2], pendm[2];
  int          cnt[2];
  logic [21:0] al[2];
  always @(posedge clk_sys) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        last[g] <= 1'b0; pendm[g] <= 1'b0; mack[g] <= 1'b0; cnt[g] <= 0;
      end else if (mr[g] != last[g]) begin
        last[g] <= mr[g]; pendm[g] <= 1'b1; cnt[g] <= lat; al[g] <= ma[g];
        if (reqcnt[g] < 256) rlog[g][reqcnt[g]] <= ma[g];
        reqcnt[g] <= reqcnt[g] + 1;
      end else if (pendm[g]) begin
        if (cnt[g] == 0) begin
          mq[g]     <= poison ? 32'hDEADBEEF : mword(al[g] - ((g == 0) ? 22'h0 : 22'h100));
          mack[g]   <= ~mack[g];
          ackcnt[g] <= ackcnt[g] + 1;
          pendm[g]  <= 1'b0;
        end else cnt[g] <= cnt[g] - 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // present an address, capture the registered byte, then strobe rd (4 cycles per byte)
  task automatic rd_at(input int a, output logic [7:0] b0, output logic [7:0] b1);
    ioctl_addr = 25'(a);
    @(negedge clk_sys);
    b0 = din0; b1 = din1;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset;
    cyc(3);
    checks++; if (din0 !== 8'h00) begin failures++; $display("FAIL rst_din got %h exp 00", din0); end
    checks++; if (mreq0 !== 1'b0) begin failures++; $display("FAIL rst_req got %b exp 0", mreq0); end
    checks++; if (maddr0 !== 22'h0) begin failures++; $display("FAIL rst_addr got %h exp 0", maddr0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy0); end
    checks++; if (urun0 !== 1'b0) begin failures++; $display("FAIL rst_underrun got %b exp 0", urun0); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_index;
    int r0;
    r0 = reqcnt[0];
    ioctl_index = 8'h05; ioctl_upload = 1'b1;
    cyc(30);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL idx_busy got %b exp 0", busy0); end
    checks++; if (reqcnt[0] != r0) begin failures++; $display("FAIL idx_reqs got %0d exp 0", reqcnt[0] - r0); end
    checks++; if (din0 !== 8'h00) begin failures++; $display("FAIL idx_din got %h exp 00", din0); end
    ioctl_upload = 1'b0; ioctl_index = 8'h00;
    cyc(2);
  endtask

  task automatic test_header;
    int          ha[20] = '{0, 1, 2, 3, 4, 5, 10, 14, 18, 19, 20, 21, 22, 23, 28, 34, 35, 36, 38, 39};
    logic [7:0]  hv[20] = '{8'h42, 8'h4D, 8'h36, 8'h30, 8'h0C, 8'h00, 8'h36, 8'h28, 8'h80, 8'h02,
                            8'h00, 8'h00, 8'h38, 8'h01, 8'h20, 8'h00, 8'h30, 8'h0C, 8'h13, 8'h0B};
    logic [7:0]  got[54];
    logic [7:0]  b0, b1;
    r0s = reqcnt[0]; r1s = reqcnt[1];
    lat = 8;
    ioctl_addr = 25'd0; ioctl_upload = 1'b1;
    @(negedge clk_sys);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL busy_rise got %b exp 1", busy0); end
    for (int a = 0; a < 54; a++) begin
      rd_at(a, b0, b1);
      got[a] = b0;
    end
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (got[ha[j]] !== hv[j]) begin
        failures++; $display("FAIL hdr[%0d] got %h exp %h", ha[j], got[ha[j]], hv[j]);
      end
    end
    checks++; if (reqcnt[0] - r0s != 2) begin failures++; $display("FAIL prefetch_cnt got %0d exp 2", reqcnt[0] - r0s); end
    checks++; if (rlog[0][r0s] !== 22'h0 || rlog[0][r0s+1] !== 22'h1) begin
      failures++; $display("FAIL prefetch_addr got %h,%h exp 0,1", rlog[0][r0s], rlog[0][r0s+1]);
    end
    checks++; if (rlog[1][r1s] !== 22'h100 || rlog[1][r1s+1] !== 22'h101) begin
      failures++; $display("FAIL prefetch_base got %h,%h exp 100,101", rlog[1][r1s], rlog[1][r1s+1]);
    end
  endtask

  task automatic test_pixels;
    logic [7:0] ev[8] = '{8'h44, 8'h33, 8'h22, A0, 8'h88, 8'h77, 8'h66, A1};
    logic [7:0] b0, b1;
    for (int a = 54; a < 62; a++) begin
      if (a == 58) begin
        checks++; if (reqcnt[0] - r0s != 2) begin failures++; $display("FAIL early_fetch got %0d exp 2", reqcnt[0] - r0s); end
      end
      rd_at(a, b0, b1);
      checks++; if (b0 !== ev[a-54]) begin failures++; $display("FAIL pix0[%0d] got %h exp %h", a, b0, ev[a-54]); end
      checks++; if (b1 !== ev[a-54]) begin failures++; $display("FAIL pix1[%0d] got %h exp %h", a, b1, ev[a-54]); end
    end
    checks++; if (reqcnt[0] - r0s != 3 || rlog[0][r0s+2] !== 22'h2) begin
      failures++; $display("FAIL third_fetch got cnt %0d addr %h exp 3 / 2", reqcnt[0] - r0s, rlog[0][r0s+2]);
    end
    checks++; if (urun0 !== 1'b0) begin failures++; $display("FAIL no_underrun got %b exp 0", urun0); end
  endtask

  task automatic test_end;
    logic [7:0] ev[8] = '{8'h02, 8'h00, 8'hDE, A2, 8'h03, 8'h00, 8'hDE, A3};
    logic [7:0] b0, b1;
    for (int a = 62; a < 70; a++) begin
      rd_at(a, b0, b1);
      checks++; if (b1 !== ev[a-62]) begin failures++; $display("FAIL tail1[%0d] got %h exp %h", a, b1, ev[a-62]); end
    end
    cyc(40);
    checks++; if (reqcnt[1] - r1s != 4) begin failures++; $display("FAIL last_word_reqs got %0d exp 4", reqcnt[1] - r1s); end
    rd_at(70, b0, b1);
    checks++; if (b1 !== 8'h00) begin failures++; $display("FAIL fsize1 got %h exp 00", b1); end
    rd_at(75, b0, b1);
    checks++; if (b1 !== 8'h00) begin failures++; $display("FAIL fsize1p5 got %h exp 00", b1); end
    rd_at(798774, b0, b1);
    checks++; if (b0 !== 8'h00) begin failures++; $display("FAIL fsize0 got %h exp 00", b0); end
    rd_at(798779, b0, b1);
    checks++; if (b0 !== 8'h00) begin failures++; $display("FAIL fsize0p5 got %h exp 00", b0); end
    cyc(20);
    checks++; if (reqcnt[1] - r1s != 4) begin failures++; $display("FAIL post_end_reqs got %0d exp 4", reqcnt[1] - r1s); end
    checks++; if (urun1 !== 1'b0) begin failures++; $display("FAIL end_underrun got %b exp 0", urun1); end
  endtask

  task automatic test_underrun;
    logic [7:0] b0, b1;
    ioctl_upload = 1'b0;
    cyc(30);
    lat = 200;
    ioctl_addr = 25'd0; ioctl_upload = 1'b1;
    cyc(5);
    rd_at(58, b0, b1);
    checks++; if (urun0 !== 1'b1) begin failures++; $display("FAIL underrun0 got %b exp 1", urun0); end
    checks++; if (urun1 !== 1'b1) begin failures++; $display("FAIL underrun1 got %b exp 1", urun1); end
    ioctl_upload = 1'b0;
    cyc(230);
    lat = 8;
    ioctl_addr = 25'd0; ioctl_upload = 1'b1;
    @(negedge clk_sys);
    checks++; if (urun0 !== 1'b0) begin failures++; $display("FAIL underrun_clr got %b exp 0", urun0); end
  endtask

  task automatic test_abort;
    int         r0, a0, rc, t;
    logic [7:0] ev[4] = '{8'h44, 8'h33, 8'h22, A0};
    logic [7:0] b0, b1;
    ioctl_upload = 1'b0;
    cyc(40);
    lat = 20;
    r0 = reqcnt[0];
    ioctl_addr = 25'd0; ioctl_upload = 1'b1;
    t = 0;
    while (reqcnt[0] == r0 && t < 50) begin @(negedge clk_sys); t++; end
    checks++; if (reqcnt[0] == r0) begin failures++; $display("FAIL abort_req_timeout got none exp 1"); end
    poison = 1'b1;
    cyc(3);
    a0 = ackcnt[0];
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL busy_fall got %b exp 0", busy0); end
    cyc(2);
    rc = reqcnt[0];
    ioctl_upload = 1'b1;
    t = 0;
    while (ackcnt[0] == a0 && t < 100) begin @(negedge clk_sys); t++; end
    checks++; if (ackcnt[0] == a0) begin failures++; $display("FAIL stale_ack_timeout got none exp 1"); end
    poison = 1'b0;
    cyc(80);
    checks++; if (rlog[0][rc] !== 22'h0 || rlog[0][rc+1] !== 22'h1) begin
      failures++; $display("FAIL restart_fetch got %h,%h exp 0,1", rlog[0][rc], rlog[0][rc+1]);
    end
    for (int a = 54; a < 58; a++) begin
      rd_at(a, b0, b1);
      checks++; if (b0 !== ev[a-54]) begin failures++; $display("FAIL stale_data[%0d] got %h exp %h", a, b0, ev[a-54]); end
    end
  endtask

  task automatic test_reset_mid;
    ioctl_addr = 25'd54;
    cyc(2);
    reset = 1'b1;
    @(negedge clk_sys);
    checks++; if (din0 !== 8'h00 || mreq0 !== 1'b0 || maddr0 !== 22'h0 || busy0 !== 1'b0 || urun0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset got din %h req %b addr %h busy %b urun %b exp all 0", din0, mreq0, maddr0, busy0, urun0);
    end
    ioctl_upload = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    @(negedge clk_sys);
    test_reset;
    test_index;
    test_header;
    test_pixels;
    test_end;
    test_underrun;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
